// File: rtl/bloco_de_controle_horner.sv
// Horner evaluator control unit: sequences X/ACC/T loads and the multiplier
// over DEGREE coefficients, with abort and a level-held start/done handshake.
module bloco_de_controle_horner #(
  parameter  int DEGREE     = 3,
  parameter  int MUL_CYCLES = 1,
  localparam int IDX_W      = (DEGREE == 0) ? 1 : $clog2(DEGREE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  output logic [IDX_W-1:0] coef_idx,
  output logic             lx,
  output logic             lacc,
  output logic             sel_acc,
  output logic             mul_en,
  output logic             lt,
  output logic             busy,
  output logic             done
);

  localparam int WC_W = $clog2(MUL_CYCLES + 1);

  localparam logic [IDX_W-1:0] K_TOP   = IDX_W'(DEGREE);
  localparam logic [WC_W-1:0]  WC_LAST = WC_W'(MUL_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_X,
    S_LOAD_TOP,
    S_MUL,
    S_ADD,
    S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_k;
  logic [IDX_W-1:0] w_k_nxt;
  logic [IDX_W-1:0] w_k_dec;
  logic [WC_W-1:0]  r_wcnt;
  logic [WC_W-1:0]  w_wcnt_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_k     <= K_TOP;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_k     <= w_k_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  assign w_k_dec  = (r_k == '0) ? r_k : r_k - 1'b1;
  assign coef_idx = r_k;

  always_comb begin
    w_state_nxt = r_state;
    w_k_nxt     = r_k;
    w_wcnt_nxt  = r_wcnt;
    lx          = 1'b0;
    lacc        = 1'b0;
    sel_acc     = 1'b0;
    mul_en      = 1'b0;
    lt          = 1'b0;
    done        = 1'b0;
    busy        = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        w_k_nxt = K_TOP;
        if (start) w_state_nxt = S_LOAD_X;
      end
      S_LOAD_X: begin
        busy        = 1'b1;
        lx          = 1'b1;
        w_state_nxt = S_LOAD_TOP;
      end
      S_LOAD_TOP: begin
        busy = 1'b1;
        lacc = 1'b1;
        if (DEGREE == 0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_k_nxt     = w_k_dec;
          w_wcnt_nxt  = '0;
          w_state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        busy       = 1'b1;
        mul_en     = 1'b1;
        w_wcnt_nxt = r_wcnt + 1'b1;
        if (r_wcnt == WC_LAST) begin
          lt          = 1'b1;
          w_state_nxt = S_ADD;
        end
      end
      S_ADD: begin
        busy    = 1'b1;
        lacc    = 1'b1;
        sel_acc = 1'b1;
        if (r_k == '0) begin
          w_state_nxt = S_DONE;
        end else begin
          w_k_nxt     = w_k_dec;
          w_wcnt_nxt  = '0;
          w_state_nxt = S_MUL;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (!start) begin
          w_k_nxt     = K_TOP;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_k_nxt     = K_TOP;
        w_wcnt_nxt  = '0;
        w_state_nxt = S_IDLE;
      end
    endcase

    // abort kills any load pulse in its own cycle and rewinds to IDLE
    if (abort && (r_state != S_IDLE)) begin
      lx          = 1'b0;
      lacc        = 1'b0;
      lt          = 1'b0;
      w_k_nxt     = K_TOP;
      w_wcnt_nxt  = '0;
      w_state_nxt = S_IDLE;
    end
  end

endmodule

// File: tb/tb_bloco_de_controle_horner.sv
// Directed bench for the Horner control unit: three parameter sets,
// handshake, abort and reset-over-abort priority.
module tb_bloco_de_controle_horner;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // a: DEGREE=3 MUL_CYCLES=1
  logic       st_a = 1'b0, ab_a = 1'b0;
  logic [1:0] ci_a;
  logic       lx_a, la_a, sa_a, me_a, lt_a, bs_a, dn_a;
  // b: DEGREE=3 MUL_CYCLES=4
  logic       st_b = 1'b0, ab_b = 1'b0;
  logic [1:0] ci_b;
  logic       lx_b, la_b, sa_b, me_b, lt_b, bs_b, dn_b;
  // c: DEGREE=0 MUL_CYCLES=1
  logic       st_c = 1'b0, ab_c = 1'b0;
  logic [0:0] ci_c;
  logic       lx_c, la_c, sa_c, me_c, lt_c, bs_c, dn_c;

  bloco_de_controle_horner #(.DEGREE(3), .MUL_CYCLES(1)) u_a (
    .clk(clk), .reset(reset), .start(st_a), .abort(ab_a),
    .coef_idx(ci_a), .lx(lx_a), .lacc(la_a), .sel_acc(sa_a),
    .mul_en(me_a), .lt(lt_a), .busy(bs_a), .done(dn_a)
  );

  bloco_de_controle_horner #(.DEGREE(3), .MUL_CYCLES(4)) u_b (
    .clk(clk), .reset(reset), .start(st_b), .abort(ab_b),
    .coef_idx(ci_b), .lx(lx_b), .lacc(la_b), .sel_acc(sa_b),
    .mul_en(me_b), .lt(lt_b), .busy(bs_b), .done(dn_b)
  );

  bloco_de_controle_horner #(.DEGREE(0), .MUL_CYCLES(1)) u_c (
    .clk(clk), .reset(reset), .start(st_c), .abort(ab_c),
    .coef_idx(ci_c), .lx(lx_c), .lacc(la_c), .sel_acc(sa_c),
    .mul_en(me_c), .lt(lt_c), .busy(bs_c), .done(dn_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ctab[7];
    ctab = '{3, 2, 2, 1, 1, 0, 0};

    step();
    step();
    @(negedge clk);
    check("rst_coef_a", ci_a, 3);
    check("rst_outs_a", {lx_a, la_a, sa_a, me_a, lt_a, bs_a, dn_a}, 0);
    check("rst_coef_c", ci_c, 0);
    step();
    reset = 1'b0;
    step();

    // Test 1 + 4: D=3 M=1, start held past done
    st_a = 1'b1;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      if (c <= 9) begin
        check($sformatf("t1_lx_%0d", c), lx_a, c == 1);
        check($sformatf("t1_lacc_%0d", c), la_a,
              (c == 2) || (c == 4) || (c == 6) || (c == 8));
        check($sformatf("t1_lt_%0d", c), lt_a,
              (c == 3) || (c == 5) || (c == 7));
        check($sformatf("t1_mul_%0d", c), me_a,
              (c == 3) || (c == 5) || (c == 7));
        check($sformatf("t1_busy_%0d", c), bs_a, (c >= 1) && (c <= 8));
      end
      if (c >= 2 && c <= 8)
        check($sformatf("t1_coef_%0d", c), ci_a, ctab[c-2]);
      check($sformatf("t1_done_%0d", c), dn_a, c >= 9);
      step();
    end
    st_a = 1'b0;
    @(negedge clk);
    check("t4_done_rel", dn_a, 1);
    step();
    @(negedge clk);
    check("t4_idle_done", dn_a, 0);
    check("t4_idle_busy", bs_a, 0);
    step();

    // Test 5: rerun, abort in 2nd MUL (run cycle 5)
    st_a = 1'b1;
    for (int r = 0; r <= 9; r++) begin
      @(negedge clk);
      if (r == 1) check("t4_relx", lx_a, 1);
      if (r == 5) begin
        check("t5_ab_lt", lt_a, 0);
        check("t5_ab_lacc", la_a, 0);
        check("t5_ab_mul", me_a, 1);
      end
      if (r == 6) begin
        check("t5_busy", bs_a, 0);
        check("t5_coef", ci_a, 3);
        check("t5_lx", lx_a, 0);
      end
      check($sformatf("t5_done_%0d", r), dn_a, 0);
      step();
      if (r == 4) begin
        ab_a = 1'b1;
        st_a = 1'b0;
      end
      if (r == 5) ab_a = 1'b0;
    end

    // Test 2: D=3 M=4
    st_b = 1'b1;
    for (int c = 0; c <= 19; c++) begin
      @(negedge clk);
      check($sformatf("t2_mul_%0d", c), me_b,
            (c >= 3 && c <= 6) || (c >= 8 && c <= 11) ||
            (c >= 13 && c <= 16));
      check($sformatf("t2_lt_%0d", c), lt_b,
            (c == 6) || (c == 11) || (c == 16));
      check($sformatf("t2_lacc_%0d", c), la_b,
            (c == 2) || (c == 7) || (c == 12) || (c == 17));
      check($sformatf("t2_done_%0d", c), dn_b, c >= 18);
      step();
    end
    st_b = 1'b0;
    step();

    // Test 3: D=0
    st_c = 1'b1;
    for (int c = 0; c <= 5; c++) begin
      @(negedge clk);
      check($sformatf("t3_lx_%0d", c), lx_c, c == 1);
      check($sformatf("t3_lacc_%0d", c), la_c, c == 2);
      check($sformatf("t3_sel_%0d", c), sa_c, 0);
      check($sformatf("t3_coef_%0d", c), ci_c, 0);
      check($sformatf("t3_mul_%0d", c), me_c, 0);
      check($sformatf("t3_done_%0d", c), dn_c, c >= 3);
      step();
    end
    st_c = 1'b0;
    step();

    // Test 6: reset together with abort in ADD (run cycle 4)
    st_a = 1'b1;
    for (int r = 0; r <= 6; r++) begin
      @(negedge clk);
      if (r == 4) check("t6_add_coef", ci_a, 2);
      if (r == 5) begin
        check("t6_coef", ci_a, 3);
        check("t6_outs", {lx_a, la_a, sa_a, me_a, lt_a, bs_a, dn_a}, 0);
      end
      if (r == 6) check("t6_stay_idle", bs_a, 0);
      step();
      if (r == 3) begin
        reset = 1'b1;
        ab_a  = 1'b1;
        st_a  = 1'b0;
      end
      if (r == 4) begin
        reset = 1'b0;
        ab_a  = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
